// File: rtl/regfile_writeback.sv
// Register-file write-back merger: port A (ALU) always wins the single write port, port B (load/multicycle)
// collisions park in a small FIFO whose entries are killed by younger A writes. Optional macro: WB_FWD_EN.
module regfile_writeback #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic            a_valid_i,
    input  logic [4:0]      a_rdId_i,
    input  logic [XLEN-1:0] a_data_i,
    input  logic            b_valid_i,
    output logic            b_ready_o,
    input  logic [4:0]      b_rdId_i,
    input  logic [XLEN-1:0] b_data_i,
`ifdef WB_FWD_EN
    input  logic [4:0]      fwd_rsId_i,
    output logic            fwd_hit_o,
    output logic [XLEN-1:0] fwd_data_o,
`endif
    output logic [4:0]      rdId_o,
    output logic [XLEN-1:0] rdData_o,
    output logic            busy_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0] valid_q;
    logic [4:0]       id_q   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [4:0]       rdId_q, rdId_d;
    logic [XLEN-1:0]  rdData_q, rdData_d;

    logic aWrite, bAccept, bLive, fifoEmpty, push, pop;

    assign b_ready_o = (count_q != FULL);
    assign fifoEmpty = (count_q == '0);
    assign rdId_o    = rdId_q;
    assign rdData_o  = rdData_q;
    assign busy_o    = !fifoEmpty || (rdId_q != 5'd0);

    // A B result aimed at the same register as a simultaneous A write is older and therefore dead on arrival.
    always_comb begin
        aWrite   = a_valid_i && (a_rdId_i != 5'd0);
        bAccept  = b_valid_i && b_ready_o;
        bLive    = bAccept && (b_rdId_i != 5'd0) && !(aWrite && (a_rdId_i == b_rdId_i));
        push     = 1'b0;
        pop      = 1'b0;
        rdId_d   = 5'd0;
        rdData_d = '0;
        if (aWrite) begin
            rdId_d   = a_rdId_i;
            rdData_d = a_data_i;
            push     = bLive;
        end else if (!fifoEmpty) begin
            pop  = 1'b1;
            push = bLive;
            if (valid_q[rptr_q]) begin
                rdId_d   = id_q[rptr_q];
                rdData_d = data_q[rptr_q];
            end
        end else if (bLive) begin
            rdId_d   = b_rdId_i;
            rdData_d = b_data_i;
        end
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rdId_q   <= 5'd0;
            rdData_q <= '0;
            valid_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]   <= 5'd0;
                data_q[i] <= '0;
            end
        end else begin
            rdId_q   <= rdId_d;
            rdData_q <= rdData_d;
            count_q  <= count_d;
            // Killed entries keep their slot so FIFO order and occupancy stay simple.
            for (int i = 0; i < DEPTH; i++) begin
                if (aWrite && (id_q[i] == a_rdId_i)) begin
                    valid_q[i] <= 1'b0;
                end
            end
            if (pop) begin
                valid_q[rptr_q] <= 1'b0;
                rptr_q          <= rptr_q + PW'(1);
            end
            if (push) begin
                valid_q[wptr_q] <= 1'b1;
                id_q[wptr_q]    <= b_rdId_i;
                data_q[wptr_q]  <= b_data_i;
                wptr_q          <= wptr_q + PW'(1);
            end
        end
    end

`ifdef WB_FWD_EN
    logic [PW-1:0] fwdIdx;

    // Scan oldest to youngest so the last live match wins; the in-flight output overrides the FIFO.
    always_comb begin
        fwdIdx     = rptr_q;
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        if (fwd_rsId_i != 5'd0) begin
            for (int k = 0; k < DEPTH; k++) begin
                fwdIdx = rptr_q + PW'(k);
                if (valid_q[fwdIdx] && (id_q[fwdIdx] == fwd_rsId_i)) begin
                    fwd_hit_o  = 1'b1;
                    fwd_data_o = data_q[fwdIdx];
                end
            end
            if (rdId_q == fwd_rsId_i) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = rdData_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus randomized traffic against a queue-based
// model of the pending-write FIFO. Forwarding checks are compiled in with WB_FWD_EN.
module tb_regfile_writeback;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk_i = 1'b0;
    logic            resetn_i = 1'b0;
    logic            a_valid_i = 1'b0;
    logic [4:0]      a_rdId_i = '0;
    logic [XLEN-1:0] a_data_i = '0;
    logic            b_valid_i = 1'b0;
    logic            b_ready_o;
    logic [4:0]      b_rdId_i = '0;
    logic [XLEN-1:0] b_data_i = '0;
    logic [4:0]      rdId_o;
    logic [XLEN-1:0] rdData_o;
    logic            busy_o;
`ifdef WB_FWD_EN
    logic [4:0]      fwd_rsId_i = '0;
    logic            fwd_hit_o;
    logic [XLEN-1:0] fwd_data_o;
`endif

    regfile_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .resetn_i(resetn_i),
        .a_valid_i(a_valid_i), .a_rdId_i(a_rdId_i), .a_data_i(a_data_i),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_rdId_i(b_rdId_i), .b_data_i(b_data_i),
`ifdef WB_FWD_EN
        .fwd_rsId_i(fwd_rsId_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
`endif
        .rdId_o(rdId_o), .rdData_o(rdData_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int fails  = 0;

    // Model of pending B writes in program order; live clears when a younger A write supersedes it.
    typedef struct {
        logic [4:0]      id;
        logic [XLEN-1:0] data;
        bit              live;
    } entry_t;
    entry_t          pend[$];
    logic [4:0]      expId;
    logic [XLEN-1:0] expData;
    logic            expReady;
    logic            expBusy;
    logic            dutReady;

    task automatic modelReset();
        pend.delete();
        expId   = '0;
        expData = '0;
        expBusy = 1'b0;
    endtask

    // Applies one cycle of inputs, advances the model, and returns just after the clock edge.
    task automatic drive(input logic av, input logic [4:0] aid, input logic [XLEN-1:0] ad,
                         input logic bv, input logic [4:0] bid, input logic [XLEN-1:0] bd);
        bit     aW, bAcc, bLive;
        entry_t e, h;
        a_valid_i = av; a_rdId_i = aid; a_data_i = ad;
        b_valid_i = bv; b_rdId_i = bid; b_data_i = bd;
        #1;
        dutReady = b_ready_o;
        expReady = (pend.size() != DEPTH);
        aW    = av && (aid != 0);
        bAcc  = bv && expReady;
        bLive = bAcc && (bid != 0) && !(aW && aid == bid);
        if (aW) foreach (pend[i]) if (pend[i].id == aid) pend[i].live = 0;
        e.id = bid; e.data = bd; e.live = 1;
        expId = '0; expData = '0;
        if (aW) begin
            expId = aid; expData = ad;
            if (bLive) pend.push_back(e);
        end else if (pend.size() > 0) begin
            h = pend.pop_front();
            if (h.live) begin expId = h.id; expData = h.data; end
            if (bLive) pend.push_back(e);
        end else if (bLive) begin
            expId = bid; expData = bd;
        end
        expBusy = (pend.size() != 0) || (expId != 0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        resetn_i = 1'b0;
        modelReset();
        #3;
        checks++; if (rdId_o !== 5'd0) begin fails++; $display("[TB] FAIL reset_rdId: got %0d expected 0", rdId_o); end
        checks++; if (rdData_o !== '0) begin fails++; $display("[TB] FAIL reset_rdData: got %h expected 0", rdData_o); end
        checks++; if (busy_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (b_ready_o !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", b_ready_o); end
        @(negedge clk_i);
        resetn_i = 1'b1;
        @(posedge clk_i);
        #1;
        idle();
        checks++; if (rdId_o !== 5'd0) begin fails++; $display("[TB] FAIL post_reset_rdId: got %0d expected 0", rdId_o); end
    endtask

    task automatic test_bypass();
        drive(0, 0, 0, 1, 5, 32'h11);
        checks++; if (rdId_o !== 5'd5 || rdData_o !== 32'h11) begin fails++;
            $display("[TB] FAIL bypass_write: got x%0d=%h expected x5=11", rdId_o, rdData_o); end
        idle();
        checks++; if (rdId_o !== 5'd0) begin fails++; $display("[TB] FAIL bypass_hold: got %0d expected 0", rdId_o); end
    endtask

    task automatic test_collision();
        drive(1, 3, 32'hA, 1, 7, 32'hB);
        checks++; if (rdId_o !== 5'd3 || rdData_o !== 32'hA) begin fails++;
            $display("[TB] FAIL collision_a: got x%0d=%h expected x3=a", rdId_o, rdData_o); end
        idle();
        checks++; if (rdId_o !== 5'd7 || rdData_o !== 32'hB) begin fails++;
            $display("[TB] FAIL collision_b: got x%0d=%h expected x7=b", rdId_o, rdData_o); end
        idle();
        checks++; if (busy_o !== 1'b0) begin fails++; $display("[TB] FAIL collision_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_x0();
        drive(0, 0, 0, 1, 0, 32'h55);
        checks++; if (rdId_o !== 5'd0 || busy_o !== 1'b0) begin fails++;
            $display("[TB] FAIL x0_b: got rdId=%0d busy=%b expected 0/0", rdId_o, busy_o); end
        drive(1, 0, 32'h77, 0, 0, 0);
        checks++; if (rdId_o !== 5'd0 || rdData_o !== '0) begin fails++;
            $display("[TB] FAIL x0_a: got x%0d=%h expected x0=0", rdId_o, rdData_o); end
    endtask

    task automatic test_kill();
        int writes9;
        writes9 = 0;
        drive(1, 1, 32'h100, 1, 9, 32'h1);
        drive(1, 9, 32'h2, 0, 0, 0);
        if (rdId_o == 5'd9) writes9++;
        checks++; if (rdId_o !== 5'd9 || rdData_o !== 32'h2) begin fails++;
            $display("[TB] FAIL kill_a: got x%0d=%h expected x9=2", rdId_o, rdData_o); end
        idle();
        if (rdId_o == 5'd9) writes9++;
        checks++; if (rdId_o !== 5'd0) begin fails++; $display("[TB] FAIL kill_pop: got %0d expected 0", rdId_o); end
        idle();
        checks++; if (writes9 != 1 || busy_o !== 1'b0) begin fails++;
            $display("[TB] FAIL kill_once: got %0d writes busy=%b expected 1 write busy=0", writes9, busy_o); end
        drive(1, 9, 32'h3, 1, 9, 32'h4);
        checks++; if (rdId_o !== 5'd9 || rdData_o !== 32'h3) begin fails++;
            $display("[TB] FAIL same_cycle_a: got x%0d=%h expected x9=3", rdId_o, rdData_o); end
        idle();
        checks++; if (rdId_o !== 5'd0 || busy_o !== 1'b0) begin fails++;
            $display("[TB] FAIL same_cycle_b: got rdId=%0d busy=%b expected 0/0", rdId_o, busy_o); end
    endtask

    task automatic test_full();
        int nextB;
        nextB = 10;
        for (int c = 0; c < 6; c++) begin
            drive(1, 1, 32'(c), 1, 5'(nextB), 32'(nextB * 16));
            if (expReady) nextB++;
            checks++; if (dutReady !== (c < 4)) begin fails++;
                $display("[TB] FAIL full_ready[%0d]: got %b expected %b", c, dutReady, (c < 4)); end
            checks++; if (rdId_o !== 5'd1 || rdData_o !== 32'(c)) begin fails++;
                $display("[TB] FAIL full_a[%0d]: got x%0d=%h expected x1=%h", c, rdId_o, rdData_o, c); end
        end
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, nextB <= 14, 5'(nextB), 32'(nextB * 16));
            if (expReady && nextB <= 14) nextB++;
            checks++; if (rdId_o !== 5'(10 + k) || rdData_o !== 32'((10 + k) * 16)) begin fails++;
                $display("[TB] FAIL drain[%0d]: got x%0d=%h expected x%0d=%h", k, rdId_o, rdData_o, 10 + k, (10 + k) * 16); end
        end
        idle();
        checks++; if (busy_o !== 1'b0) begin fails++; $display("[TB] FAIL drain_busy: got %b expected 0", busy_o); end
    endtask

`ifdef WB_FWD_EN
    task automatic test_fwd();
        drive(1, 1, 32'h1111, 1, 4, 32'h44);
        fwd_rsId_i = 5'd4; #1;
        checks++; if (fwd_hit_o !== 1'b1 || fwd_data_o !== 32'h44) begin fails++;
            $display("[TB] FAIL fwd_fifo: got hit=%b data=%h expected 1/44", fwd_hit_o, fwd_data_o); end
        fwd_rsId_i = 5'd1; #1;
        checks++; if (fwd_hit_o !== 1'b1 || fwd_data_o !== 32'h1111) begin fails++;
            $display("[TB] FAIL fwd_out: got hit=%b data=%h expected 1/1111", fwd_hit_o, fwd_data_o); end
        fwd_rsId_i = 5'd6; #1;
        checks++; if (fwd_hit_o !== 1'b0 || fwd_data_o !== '0) begin fails++;
            $display("[TB] FAIL fwd_miss: got hit=%b data=%h expected 0/0", fwd_hit_o, fwd_data_o); end
        fwd_rsId_i = 5'd0;
        idle();
        idle();
    endtask
`endif

    task automatic test_random();
        logic            av, bv;
        logic [4:0]      aid, bid;
        for (int i = 0; i < 400; i++) begin
            av  = ($urandom_range(0, 99) < ((i % 100) < 50 ? 85 : 25));
            bv  = ($urandom_range(0, 99) < 70);
            aid = 5'($urandom_range(0, 7));
            bid = 5'($urandom_range(0, 7));
            drive(av, aid, $urandom, bv, bid, $urandom);
            checks++; if (dutReady !== expReady) begin fails++;
                $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", i, dutReady, expReady); end
            checks++; if (rdId_o !== expId) begin fails++;
                $display("[TB] FAIL rand_rdId[%0d]: got %0d expected %0d", i, rdId_o, expId); end
            if (expId != 0) begin
                checks++; if (rdData_o !== expData) begin fails++;
                    $display("[TB] FAIL rand_rdData[%0d]: got %h expected %h", i, rdData_o, expData); end
            end
            checks++; if (busy_o !== expBusy) begin fails++;
                $display("[TB] FAIL rand_busy[%0d]: got %b expected %b", i, busy_o, expBusy); end
        end
        for (int i = 0; i < DEPTH + 2; i++) idle();
    endtask

    task automatic test_reset_midstream();
        drive(1, 1, 32'h1, 1, 20, 32'h20);
        drive(1, 2, 32'h2, 1, 21, 32'h21);
        drive(1, 3, 32'h3, 1, 22, 32'h22);
        checks++; if (busy_o !== 1'b1 || pend.size() != 3) begin fails++;
            $display("[TB] FAIL midreset_setup: got busy=%b expected 1 with 3 queued", busy_o); end
        a_valid_i = 0; b_valid_i = 0;
        #2;
        resetn_i = 1'b0;
        modelReset();
        #1;
        checks++; if (rdId_o !== 5'd0 || busy_o !== 1'b0 || b_ready_o !== 1'b1) begin fails++;
            $display("[TB] FAIL midreset_now: got rdId=%0d busy=%b ready=%b expected 0/0/1", rdId_o, busy_o, b_ready_o); end
        @(negedge clk_i);
        resetn_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            idle();
            checks++; if (rdId_o !== 5'd0) begin fails++;
                $display("[TB] FAIL midreset_after[%0d]: got %0d expected 0", k, rdId_o); end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_collision();
        test_x0();
        test_kill();
        test_full();
`ifdef WB_FWD_EN
        test_fwd();
`endif
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
